credit_sender_dataless: RTL and testbench
=========================================

CREDIT_SENDER_DATALESS -- requirements
Module: credit_sender_dataless

Interface
REQ-001 SHALL have parameter: CREDITS, default 4, number of downstream buffer slots owned by this sender; legal range 1..255.
REQ-002 SHALL have derived constant CW = clog2(CREDITS+1), the width of the credit count.
REQ-003 SHALL have port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port: ins_valid  input  1  upstream token offered.
REQ-006 SHALL have port: ins_ready  output  1  a credit is available, so the token is accepted this cycle.
REQ-007 SHALL have port: outs_valid  output  1  registered one-cycle pulse; one token pushed to the downstream buffer.
REQ-008 SHALL have port: credit_in  input  1  one-cycle pulse; the downstream buffer freed one slot.
REQ-009 SHALL have port: credits  output  CW  current credit count, registered.
REQ-010 SHALL have port: overflow_err  output  1  sticky flag; a credit was returned while the count was already at CREDITS.

Function
REQ-011 SHALL keep the credit count cnt in the range 0..CREDITS; credits SHALL equal cnt at all times.
REQ-012 SHALL drive ins_ready = (cnt != 0) from registered state only; there SHALL be no combinational path from credit_in or ins_valid to ins_ready.
REQ-013 SHALL define send = ins_valid & ins_ready.
REQ-014 SHALL register outs_valid <= send, giving a latency of exactly 1 cycle from acceptance to outs_valid.
REQ-015 SHALL produce exactly one outs_valid pulse per accepted token, and no pulse in any other cycle.
REQ-016 SHALL update cnt as follows: send only -> cnt-1; credit_in only -> cnt+1; both -> unchanged; neither -> unchanged.
REQ-017 SHALL, when cnt==0 and credit_in arrives, raise cnt to 1 at the next edge; ins_ready SHALL rise in that next cycle, never in the same cycle.
REQ-018 SHALL, when cnt==CREDITS and credit_in arrives without a send, hold cnt at CREDITS and set overflow_err to 1.
REQ-019 SHALL, when cnt==CREDITS with both send and credit_in, leave cnt unchanged and raise no error.
REQ-020 SHALL hold overflow_err at 1 once set, until rst.
REQ-021 SHALL allow ins_valid to deassert without completing a handshake; no token is consumed unless send is true.
REQ-022 SHALL sustain a throughput of 1 token/cycle whenever cnt>0 and credits return at the same rate.

Reset
REQ-023 SHALL, while rst is asserted, force cnt=CREDITS, outs_valid=0, overflow_err=0; ins_ready SHALL read 1.
REQ-024 SHALL, if rst is asserted mid-operation, drop any in-flight outs_valid pulse immediately; credits lost downstream are not reconciled, and downstream SHALL be reset together with this block.
REQ-025 SHALL ignore credit_in and ins_valid in the first edge after rst deasserts only if rst is still high at that edge; otherwise normal operation resumes on the first edge.

Structure
REQ-026 SHALL place the CW width function (clog2 of N+1) in the shared support package alongside the other width helpers; no new typedefs are needed.
REQ-027 SHALL be implemented as one top module plus one sub-module, credit_counter (parameter MAX; inputs inc, dec; outputs count, at_zero, ovf), instantiated once.
REQ-028 SHALL be dataless; the data-carrying variant SHALL wrap this block, pass data through a register that is enabled by send, and add no further control.

Verification (CREDITS=4)
REQ-029 SHALL verify reset: after rst, credits==4, ins_ready==1, outs_valid==0, overflow_err==0.
REQ-030 SHALL verify drain: ins_valid=1 held for 6 cycles with no credit_in -> exactly 4 outs_valid pulses, each 1 cycle after acceptance; credits counts 3,2,1,0; ins_ready==0 from cycle 4.
REQ-031 SHALL verify refill from zero: at credits==0, pulse credit_in once -> ins_ready==1 on the next cycle only, one token accepted, credits back to 0.
REQ-032 SHALL verify simultaneous events: credits==2, ins_valid=1 and credit_in=1 held for 10 cycles -> 10 outs_valid pulses and credits constant at 2.
REQ-033 SHALL verify overflow: at credits==4, pulse credit_in -> credits stays 4, overflow_err==1 and stays 1 until rst.
REQ-034 SHALL verify reset mid-burst: assert rst while credits==1 and outs_valid==1 -> outs_valid==0 immediately; credits==4 after release.

Source files
------------

// File: rtl/credit_sender_dataless_pkg.sv
// Shared width helpers for the credit sender and its counter.
package credit_sender_dataless_pkg;

  // Bits needed to hold any value 0..n inclusive.
  function automatic int cw_of(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n distinct items.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/credit_sender_dataless_credit_counter.sv
// Saturating credit counter: resets full, counts down on dec, up on inc, flags a return beyond MAX.
module credit_counter
  import credit_sender_dataless_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = cw_of(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_zero,
  output logic         ovf
);

  localparam logic [W-1:0] FULL = W'(MAX);
  localparam logic [W-1:0] ONE  = W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= FULL;
      ovf   <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          // A return with no slot outstanding means downstream lost track.
          if (count == FULL) ovf <= 1'b1;
          else               count <= count + ONE;
        end
        2'b01: begin
          if (count != '0) count <= count - ONE;
        end
        default: ;
      endcase
    end
  end

  assign at_zero = (count == '0);

endmodule

// File: rtl/credit_sender_dataless.sv
// Dataless credit-based sender: accepts a token whenever a credit is held, pulses outs_valid one cycle later.
module credit_sender_dataless
  import credit_sender_dataless_pkg::*;
#(
  parameter int CREDITS = 4,
  localparam int CW = cw_of(CREDITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ins_valid,
  output logic          ins_ready,
  output logic          outs_valid,
  input  logic          credit_in,
  output logic [CW-1:0] credits,
  output logic          overflow_err
);

  logic at_zero;
  logic send;

  credit_counter #(.MAX(CREDITS)) u_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (credit_in),
    .dec     (send),
    .count   (credits),
    .at_zero (at_zero),
    .ovf     (overflow_err)
  );

  // Ready depends only on the registered count, never on this cycle's credit_in.
  assign ins_ready = ~at_zero;
  assign send      = ins_valid & ins_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) outs_valid <= 1'b0;
    else     outs_valid <= send;
  end

endmodule

// File: tb/tb_credit_sender_dataless.sv
module tb_credit_sender_dataless;

  logic       clk;
  logic       rst;
  logic       ins_valid;
  logic       ins_ready;
  logic       outs_valid;
  logic       credit_in;
  logic [2:0] credits;
  logic       overflow_err;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  credit_sender_dataless #(.CREDITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .outs_valid   (outs_valid),
    .credit_in    (credit_in),
    .credits      (credits),
    .overflow_err (overflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance past one rising edge; outputs then reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ins_valid = 1'b0;
    credit_in = 1'b0;
    step();
    chk("rst_credits", credits, 4);
    chk("rst_ready", ins_ready, 1);
    chk("rst_outs", outs_valid, 0);
    chk("rst_ovf", overflow_err, 0);
    rst = 1'b0;
    step();
    chk("post_rst_credits", credits, 4);
    chk("post_rst_ovf", overflow_err, 0);

    // Drain: six cycles of offers, only four credits
    ins_valid = 1'b1;
    #1;
    chk("drain_no_comb_pulse", outs_valid, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (outs_valid) pulses++;
      chk("drain_credits", credits, (i < 3) ? 3 - i : 0);
      chk("drain_ready", ins_ready, (i < 3) ? 1 : 0);
      chk("drain_outs", outs_valid, (i < 4) ? 1 : 0);
    end
    chk("drain_pulses", pulses, 4);
    ins_valid = 1'b0;
    step();
    chk("drain_idle_outs", outs_valid, 0);

    // Refill from zero with one returned credit
    credit_in = 1'b1;
    ins_valid = 1'b1;
    #1;
    chk("refill_ready_same_cycle", ins_ready, 0);
    step();
    credit_in = 1'b0;
    chk("refill_credits1", credits, 1);
    chk("refill_ready1", ins_ready, 1);
    chk("refill_outs_early", outs_valid, 0);
    step();
    chk("refill_credits0", credits, 0);
    chk("refill_ready0", ins_ready, 0);
    chk("refill_outs", outs_valid, 1);
    step();
    chk("refill_outs_single", outs_valid, 0);
    ins_valid = 1'b0;

    // Bring count to 2, then send and return together for 10 cycles
    credit_in = 1'b1;
    step();
    step();
    chk("sim_setup_credits", credits, 2);
    ins_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (outs_valid) pulses++;
      chk("sim_credits", credits, 2);
    end
    chk("sim_pulses", pulses, 10);
    ins_valid = 1'b0;
    credit_in = 1'b0;
    step();
    chk("sim_tail_outs", outs_valid, 0);
    chk("sim_tail_credits", credits, 2);

    // Overflow: fill to 4, then return one more
    credit_in = 1'b1;
    step();
    step();
    chk("ovf_full_credits", credits, 4);
    chk("ovf_before", overflow_err, 0);
    step();
    credit_in = 1'b0;
    chk("ovf_credits_held", credits, 4);
    chk("ovf_set", overflow_err, 1);
    ins_valid = 1'b1;
    step();
    chk("ovf_sticky", overflow_err, 1);
    chk("ovf_after_send_credits", credits, 3);

    // Reset mid-burst with a pulse in flight
    step();
    step();
    chk("mid_credits", credits, 1);
    chk("mid_outs", outs_valid, 1);
    chk("mid_ovf_still", overflow_err, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", outs_valid, 0);
    chk("mid_rst_credits", credits, 4);
    chk("mid_rst_ovf", overflow_err, 0);
    ins_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("mid_release_credits", credits, 4);

    // Full count with send and return together: no error
    ins_valid = 1'b1;
    credit_in = 1'b1;
    step();
    ins_valid = 1'b0;
    credit_in = 1'b0;
    chk("full_both_credits", credits, 4);
    chk("full_both_ovf", overflow_err, 0);
    chk("full_both_outs", outs_valid, 1);
    step();
    chk("full_both_outs_end", outs_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
